// File: rtl/fp_accum_ctrl.sv
// Sequencer that sums `count` single-precision operands through an external
// combinational adder. Define FP_ACC_SPECIAL_EN to add the sticky `special` (Inf/NaN seen) output.
module fp_accum_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_s,
    output logic             out_valid,
    output logic [31:0]      out_sum,
    output logic             busy
`ifdef FP_ACC_SPECIAL_EN
    ,
    output logic             special
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        ADD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] remaining_dec;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      op_q, op_d;
    logic [31:0]      out_sum_q, out_sum_d;
    logic             xfer;

    assign in_ready  = (state_q == LOAD) || (state_q == FETCH);
    assign xfer      = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign add_a     = acc_q;
    assign add_b     = op_q;
    assign out_sum   = out_sum_q;

    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        acc_d         = acc_q;
        op_d          = op_q;
        out_sum_d     = out_sum_q;
        // Saturating decrement keeps the counter from wrapping below zero.
        remaining_dec = (remaining_q != '0) ? remaining_q - CNT_W'(1) : '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = count;
                    acc_d       = '0;
                    op_d        = '0;
                    state_d     = (count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    acc_d       = in_data;
                    remaining_d = remaining_dec;
                    state_d     = (remaining_dec == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    op_d        = in_data;
                    remaining_d = remaining_dec;
                    state_d     = ADD;
                end
            end
            ADD: begin
                acc_d   = add_s;
                state_d = (remaining_q == '0) ? DONE : FETCH;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Result register is loaded on DONE entry so it is valid during the pulse and holds after.
        if (state_d == DONE) begin
            out_sum_d = acc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_q       <= '0;
            op_q        <= '0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            out_sum_q   <= out_sum_d;
        end
    end

`ifdef FP_ACC_SPECIAL_EN
    logic special_q, special_d;

    // Exponent 8'hFF marks Inf or NaN on either the accepted operand or the adder result.
    always_comb begin
        special_d = special_q;
        if ((state_q == IDLE) && start) begin
            special_d = 1'b0;
        end else if (xfer && (in_data[30:23] == 8'hFF)) begin
            special_d = 1'b1;
        end else if ((state_q == ADD) && (add_s[30:23] == 8'hFF)) begin
            special_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            special_q <= 1'b0;
        end else begin
            special_q <= special_d;
        end
    end

    assign special = special_q;
`endif

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Self-checking bench for fp_accum_ctrl: integer-valued floats let a plain integer
// sum serve as the reference, and a bench adder closes the add_a/add_b/add_s loop.
module tb_fp_accum_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             inValid;
    logic [31:0]      inData;
    logic             inReady;
    logic [31:0]      addA;
    logic [31:0]      addB;
    logic [31:0]      addS;
    logic             outValid;
    logic [31:0]      outSum;
    logic             busy;
`ifdef FP_ACC_SPECIAL_EN
    logic             specialOut;
    logic             lastSpecial;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] opsQ[$];

    fp_accum_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .in_valid  (inValid),
        .in_data   (inData),
        .in_ready  (inReady),
        .add_a     (addA),
        .add_b     (addB),
        .add_s     (addS),
        .out_valid (outValid),
        .out_sum   (outSum),
        .busy      (busy)
`ifdef FP_ACC_SPECIAL_EN
        ,
        .special   (specialOut)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] intToFloat(input int v);
        int a;
        int p;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 24; i++) if (a[i]) p = i;
        m = 32'(a) << (23 - p);
        return {(v < 0), 8'(127 + p), m[22:0]};
    endfunction

    function automatic int floatToInt(input logic [31:0] f);
        int e;
        int mag;
        if (f[30:23] == 8'h00) return 0;
        e   = int'(f[30:23]) - 127;
        mag = int'({1'b1, f[22:0]}) >> (23 - e);
        return f[31] ? -mag : mag;
    endfunction

    // Bench adder: exact for integer-valued operands, Inf if either side is Inf/NaN.
    always_comb begin
        if ((addA[30:23] == 8'hFF) || (addB[30:23] == 8'hFF)) addS = 32'h7F800000;
        else addS = intToFloat(floatToInt(addA) + floatToInt(addB));
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pickGap(input int gapMode);
        return (gapMode < 0) ? int'($urandom_range(0, 3)) : gapMode;
    endfunction

    // Runs one accumulation over opsQ; gapMode<0 picks random stalls, noise adds junk in_valid and start storms.
    task automatic applyStimulus(input int n, input int gapMode, input bit noise,
                                 input logic [31:0] expSum, input string tag);
        int idx = 0;
        int gapLeft;
        int gapSum;
        int cycle;
        int doneCycle = -1;
        int expCycle;
        bit took;
        gapLeft = pickGap(gapMode);
        gapSum  = (n > 0) ? gapLeft : 0;
        @(negedge clk);
        start   = 1'b1;
        count   = n[CNT_W-1:0];
        inValid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cycle = 1;
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd1);
        while (cycle <= 6 * n + 20) begin
            if (outValid) begin
                doneCycle = cycle;
                break;
            end
            if (inReady) begin
                if (gapLeft > 0) begin
                    inValid = 1'b0;
                    inData  = $urandom;
                    gapLeft--;
                end else begin
                    inValid = 1'b1;
                    inData  = opsQ[idx];
                end
            end else begin
                inValid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                inData  = $urandom;
            end
            if (noise) begin
                start = 1'b1;
                count = CNT_W'($urandom);
            end
            took = inValid && inReady;
            @(posedge clk);
            if (took) begin
                idx++;
                if (idx < n) begin
                    gapLeft = pickGap(gapMode);
                    gapSum += gapLeft;
                end
            end
            #1;
            cycle++;
        end
        start   = 1'b0;
        inValid = 1'b0;
        expCycle = (n == 0) ? 1 : 2 * n + gapSum;
        checkOutput({tag, "_cycle"}, 32'(doneCycle), 32'(expCycle));
        checkOutput({tag, "_sum"}, outSum, expSum);
        checkOutput({tag, "_consumed"}, 32'(idx), 32'(n));
        checkOutput({tag, "_rdyAtDone"}, {31'b0, inReady}, 32'd0);
`ifdef FP_ACC_SPECIAL_EN
        lastSpecial = specialOut;
`endif
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulseEnd"}, {31'b0, outValid}, 32'd0);
        checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_hold"}, outSum, expSum);
    endtask

    initial begin
        int total;
        int n;
        int v;
        rst     = 1'b1;
        start   = 1'b0;
        count   = '0;
        inValid = 1'b0;
        inData  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_outValid", {31'b0, outValid}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_inReady", {31'b0, inReady}, 32'd0);
        checkOutput("rst_outSum", outSum, 32'h0);
        checkOutput("rst_addA", addA, 32'h0);
        checkOutput("rst_addB", addB, 32'h0);

        opsQ = '{32'h3F800000, 32'h40000000, 32'h40400000};
        applyStimulus(3, 0, 1'b0, 32'h40C00000, "three");

        opsQ = {};
        applyStimulus(0, 0, 1'b0, 32'h00000000, "zero");

        opsQ = '{32'h3F800000, 32'hBF800000};
        applyStimulus(2, 3, 1'b0, 32'h00000000, "stall");

        opsQ = '{32'h40000000, 32'h40400000};
        applyStimulus(2, 0, 1'b1, 32'h40A00000, "startStorm");

        // Reset in the first ADD cycle of a four-operand run.
        opsQ = '{32'h40800000, 32'h40A00000, 32'h3F800000, 32'h3F800000};
        @(negedge clk);
        start = 1'b1;
        count = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            checkOutput("abort_noValid", {31'b0, outValid}, 32'd0);
            inValid = 1'b1;
            inData  = opsQ[c-1];
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        checkOutput("abort_addA", addA, 32'h40800000);
        checkOutput("abort_addB", addB, 32'h40A00000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_noValid2", {31'b0, outValid}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_sum", outSum, 32'h0);
        checkOutput("abort_addA0", addA, 32'h0);
        opsQ = '{32'h40000000};
        applyStimulus(1, 0, 1'b0, 32'h40000000, "afterRst");

        for (int t = 0; t < 7; t++) begin
            n = (t == 6) ? 255 : int'($urandom_range(1, 12));
            total = 0;
            opsQ = {};
            for (int k = 0; k < n; k++) begin
                v = int'($urandom_range(0, 2000)) - 1000;
                total += v;
                opsQ.push_back(intToFloat(v));
            end
            applyStimulus(n, -1, 1'b1, intToFloat(total), $sformatf("rand%0d", t));
`ifdef FP_ACC_SPECIAL_EN
            checkOutput($sformatf("rand%0d_special", t), {31'b0, lastSpecial}, 32'd0);
`endif
        end

`ifdef FP_ACC_SPECIAL_EN
        opsQ = '{32'h7F800000, 32'h3F800000};
        applyStimulus(2, 0, 1'b0, 32'h7F800000, "special");
        checkOutput("special_flag", {31'b0, lastSpecial}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fp_accum_ctrl.md
FP_ACCUM_CTRL -- requirements
Module: fp_accum_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of the operand-count field.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: start  input  1  begin an accumulation; sampled only in IDLE.
REQ-005 SHALL have port: count  input  CNT_W  number of operands to sum; latched when start is accepted.
REQ-006 SHALL have port: in_valid  input  1  in_data holds an operand.
REQ-007 SHALL have port: in_data  input  32  IEEE-754 single-precision operand.
REQ-008 SHALL have port: in_ready  output  1  block accepts an operand this cycle.
REQ-009 SHALL have ports: add_a and add_b  output  32  registered operands driven to the external combinational single-precision adder.
REQ-010 SHALL have port: add_s  input  32  sum returned by that adder.
REQ-011 SHALL have port: out_valid  output  1  one-cycle pulse; out_sum is final.
REQ-012 SHALL have port: out_sum  output  32  accumulated result.
REQ-013 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, FETCH, ADD and DONE.
REQ-015 IDLE with start=1: SHALL latch count into remaining counter; count==0 -> DONE, else -> LOAD.
REQ-016 An operand SHALL transfer only on in_valid&in_ready.
REQ-017 in_ready SHALL be 1 only in LOAD and FETCH.
REQ-018 LOAD: the transfer SHALL write in_data into acc without an add and decrement remaining; remaining==0 after decrement -> DONE, else -> FETCH.
REQ-019 FETCH: the transfer SHALL write in_data into operand register op and decrement remaining -> ADD.
REQ-020 ADD: add_a SHALL equal acc and add_b SHALL equal op, both from registers.
REQ-021 ADD: add_s SHALL be captured into acc at the end of the cycle; remaining==0 -> DONE, else -> FETCH.
REQ-022 add_s SHALL be ignored outside ADD.
REQ-023 DONE: out_valid SHALL be 1 for exactly one cycle and out_sum SHALL equal acc.
REQ-024 DONE SHALL return to IDLE unconditionally.
REQ-025 count==0 SHALL give out_sum=32'h00000000.
REQ-026 out_sum SHALL hold its value until the next DONE.
REQ-027 Latency with in_valid held high and start accepted in cycle 0: out_valid SHALL assert in cycle 2N for N>=1, and in cycle 1 for N=0.
REQ-028 Each in_valid=0 cycle in LOAD or FETCH SHALL add exactly one cycle; state and counters SHALL hold while waiting.
REQ-029 start asserted while busy=1 SHALL be ignored with no effect on state or counters.
REQ-030 count=2^CNT_W-1 SHALL be supported; the remaining counter SHALL never wrap below 0.
REQ-031 in_valid in IDLE, ADD or DONE SHALL consume no data.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE from any state, including mid-accumulation; the partial sum is discarded.
REQ-033 rst SHALL clear: acc, op, add_a, add_b, out_sum and remaining to 0; out_valid, busy and in_ready to 0.
REQ-034 After rst, the first accepted start SHALL behave identically to one issued after power-up.

Configuration
REQ-035 With macro FP_ACC_SPECIAL_EN defined, the block SHALL add output port special (1 bit).
REQ-036 special SHALL be cleared on rst and on each accepted start.
REQ-037 special SHALL be set sticky when any accepted operand or any captured add_s has exponent 8'hFF.
REQ-038 special SHALL remain valid alongside out_sum after DONE.
REQ-039 Without FP_ACC_SPECIAL_EN, port special and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-040 Scenario: count=3, inputs 3F800000, 40000000, 40400000, in_valid always high, bench adder in place -> out_valid in cycle 6, out_sum=40C00000.
REQ-041 Scenario: count=0 -> out_valid in cycle 1, out_sum=00000000, in_ready never high.
REQ-042 Scenario: count=2, inputs 3F800000 and BF800000, in_valid low for 3 cycles before each operand -> out_sum=00000000, out_valid in cycle 10.
REQ-043 Scenario: count=4, rst pulsed in the first ADD cycle, then count=1 with 40000000 -> no out_valid from the first run; second run gives out_sum=40000000 in cycle 2.
REQ-044 Scenario: start pulsed every cycle during a count=2 run -> exactly one out_valid, out_sum unaffected.
REQ-045 Scenario: FP_ACC_SPECIAL_EN defined, count=2, inputs 7F800000 and 3F800000 -> special=1 at out_valid; the same run with the macro undefined elaborates with no special port.
